keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Column-scanning 4x4 matrix keypad front end for the hangman host and player consoles. It sits directly upstream of the game top level and produces the decoded key events that the top level otherwise takes as raw row lines. It performs four jobs:
- drives the keypad columns one-hot
- synchronises and samples the row lines
- debounces complete 16-key snapshots
- emits a single-cycle strobe with a 4-bit key code for each clean press of exactly one key

## Interface
Parameters:
- SCAN_TICKS, default 4: clock cycles each column is driven. Must be ≥ 3.
- DEBOUNCE_CNT, default 3: number of consecutive identical sweeps required to accept a new keypad state. Must be ≥ 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- row  input  4  raw keypad row lines, active-high; row[3] = R0 … row[0] = R3.
- col  output  4  one-hot column drive; col[3] = C0 … col[0] = C3.
- key_valid  output  1  one-cycle strobe: new single-key press accepted.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} = 4·R + C; valid when key_valid is high, held until the next strobe.
- key_held  output  1  high while the debounced state is non-zero.
- multi_err  output  1  high while the debounced state has more than one key set.

## Operation
- Reset values:
  - col = 4'b1000
  - key_valid, key_code, key_held, multi_err = 0
  - snapshot, previous snapshot, debounced state (16 bits each) = 0
  - tick counter, column index, stable counter = 0
- Synchroniser: row passes through two flops (row_s) before any use.
- Scan FSM, states COL0 → COL1 → COL2 → COL3 → COL0, one state per column:
  - col is driven one-hot for the current column; the tick counter runs 0..SCAN_TICKS-1.
  - On tick SCAN_TICKS-1, row_s is written into snapshot bits [4·R + C] for the current column C, for all R.
  - At that same edge the FSM advances and col shifts right, wrapping from 4'b0001 to 4'b1000.
- Sweep end is the edge that samples COL3. At sweep end:
  - The completed snapshot is compared with the previous snapshot.
  - If equal: stable counter increments, saturating at DEBOUNCE_CNT.
  - If different: stable counter is set to 1.
  - The previous snapshot is then updated.
- Acceptance: when the stable counter reaches DEBOUNCE_CNT and the snapshot differs from the debounced state, the debounced state is loaded on the following cycle.
- Event generation on a debounced-state change:
  - 0 → exactly one bit set: key_valid = 1 for one cycle; key_code = index of the set bit.
  - Any → more than one bit set: no strobe; multi_err = 1.
  - Multi → single bit: multi_err = 0, no strobe. A fresh strobe requires a full release first.
  - Any → 0: key_held = 0, multi_err = 0, no strobe.
- key_held = (debounced ≠ 0); multi_err = (popcount(debounced) > 1). Both are registered.

## Timing
- One sweep = 4·SCAN_TICKS cycles. With the defaults, 16 cycles.
- Press latency, from row held stable through a full sweep: up to DEBOUNCE_CNT + 1 sweeps plus 2 cycles (strobe) after the first sweep whose snapshot contains the key.
- key_valid is never high on two consecutive cycles. At most one strobe occurs per press-release pair.
- Release latency: equal to press latency; key_held drops on the same cycle the strobe would fire.
- Bounce rule: any snapshot change restarts debouncing. A row glitch that misses the sample tick has no effect.
- Reset mid-operation: all state clears immediately and col returns to 4'b1000. A key still held after reset is seen as a new press and strobes after the normal latency.

## Test plan
All scenarios use SCAN_TICKS = 4, DEBOUNCE_CNT = 3.
- Reset: assert rst for 2 cycles → col = 4'b1000, all outputs 0, and col walks 1000 → 0100 → 0010 → 0001 → 1000 every 4 cycles after release.
- Press R0 C1 (row = 4'b1000 while col = 4'b0100), held for 10 sweeps → exactly one key_valid, with key_code = 4'd1 and key_held = 1. Release → key_held = 0 within 5 sweeps, with no further strobe.
- Press R3 C0 (row = 4'b0001 while col = 4'b1000) → one strobe with key_code = 4'd12. Then press R2 C0 → key_code = 4'd8.
- Bounce: toggle R2 C0 every 8 cycles for 64 cycles, then hold stable → exactly one strobe, key_code = 4'd8.
- Multi-key: hold R0 C1 + R2 C0 → multi_err = 1, no strobe. Drop R2 C0 → multi_err = 0, no strobe. Full release, then press R0 C1 → one strobe, key_code = 4'd1.
- Reset mid-press: assert rst while R0 C1 is held and key_held = 1 → all outputs 0 the same cycle. After release of rst, one strobe with key_code = 4'd1.

Source files
------------

// File: rtl/keypad_if.sv
// rtl/keypad_if.sv - keypad matrix lines and decoded key event signals
//
// Signals:
//   row        keypad row lines into the scanner, active-high (row[3] = R0)
//   col        one-hot column drive from the scanner (col[3] = C0)
//   key_valid  one-cycle strobe for a clean single-key press
//   key_code   {row_idx, col_idx} of the accepted key, held between strobes
//   key_held   debounced state is non-zero
//   multi_err  debounced state has more than one key set
//
// Modports:
//   master  the scanner side (drives col and the key event outputs)
//   slave   the keypad/consumer side (drives row)

interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic       multi_err;

  modport master (
    input  row,
    output col,
    output key_valid,
    output key_code,
    output key_held,
    output multi_err
  );

  modport slave (
    output row,
    input  col,
    input  key_valid,
    input  key_code,
    input  key_held,
    input  multi_err
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column-scanning 4x4 keypad front end with sweep debouncing
//
// Parameters:
//   SCAN_TICKS    clock cycles each column is driven (>= 3, leaves room for the
//                 two-flop row synchroniser to settle after a column change)
//   DEBOUNCE_CNT  consecutive identical sweeps needed to accept a new state (>= 1)
//
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   kp   keypad_if.master: row in; col, key_valid, key_code, key_held,
//        multi_err out

module keypad_scanner #(
  parameter int SCAN_TICKS   = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int SW = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [TW-1:0] LAST_TICK = TW'(SCAN_TICKS - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_CNT);

  // State value doubles as the current column index.
  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

  // Only called on a one-hot vector, so priority order does not matter.
  function automatic logic [3:0] encode16(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [3:0]    row_meta_q, row_s_q;
  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    col_q, col_d;
  logic [15:0]   snap_q, snap_d;
  logic [15:0]   prev_q, prev_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [15:0]   deb_q, deb_d;
  logic [15:0]   deb_last_q;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_held_q, key_held_d;
  logic          multi_err_q, multi_err_d;

  logic [1:0]    col_idx;
  logic          sample;
  logic          sweep_end;
  logic [4:0]    deb_pop;

  assign col_idx = state_q;
  assign deb_pop = popcount16(deb_q);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q  <= '0;
      row_s_q     <= '0;
      state_q     <= COL0;
      tick_q      <= '0;
      col_q       <= 4'b1000;
      snap_q      <= '0;
      prev_q      <= '0;
      stable_q    <= '0;
      deb_q       <= '0;
      deb_last_q  <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      row_meta_q  <= kp.row;
      row_s_q     <= row_meta_q;
      state_q     <= state_d;
      tick_q      <= tick_d;
      col_q       <= col_d;
      snap_q      <= snap_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      deb_q       <= deb_d;
      deb_last_q  <= deb_q;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      multi_err_q <= multi_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Scan FSM and snapshot capture
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + 1'b1;
    col_d   = col_q;
    snap_d  = snap_q;
    sample  = 1'b0;

    if (tick_q == LAST_TICK) begin
      sample = 1'b1;
      tick_d = '0;
      col_d  = {col_q[0], col_q[3:1]};
      // row_s[3-R] carries row R; it lands at snapshot bit 4*R + C.
      for (int r = 0; r < 4; r++) begin
        snap_d[{r[1:0], col_idx}] = row_s_q[3-r];
      end
      unique case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        COL2:    state_d = COL3;
        COL3:    state_d = COL0;
        default: state_d = COL0;
      endcase
    end
  end

  assign sweep_end = sample && (state_q == COL3);

  // --------------------------------------------------------------------------
  // Sweep-level debouncing
  // --------------------------------------------------------------------------
  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    deb_d    = deb_q;

    if (sweep_end) begin
      // snap_d is the completed sweep, including the column sampled now.
      prev_d = snap_d;
      if (snap_d == prev_q) begin
        stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 1'b1;
      end else begin
        stable_d = SW'(1);
      end
    end

    // prev_q holds the last completed sweep and only moves at sweep end, so
    // the partially rewritten snap_q of the sweep in progress is never loaded.
    if ((stable_q == STABLE_MAX) && (prev_q != deb_q)) begin
      deb_d = prev_q;
    end
  end

  // --------------------------------------------------------------------------
  // Key events
  // --------------------------------------------------------------------------
  always_comb begin
    // A strobe needs the previous debounced state to be empty; deb_last_q
    // catches up one cycle later, so the strobe is exactly one cycle wide and
    // a multi -> single transition never strobes.
    key_valid_d = (deb_last_q == 16'h0000) && (deb_pop == 5'd1);
    key_code_d  = key_valid_d ? encode16(deb_q) : key_code_q;
    key_held_d  = (deb_q != 16'h0000);
    multi_err_d = (deb_pop > 5'd1);
  end

  assign kp.col       = col_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_held  = key_held_q;
  assign kp.multi_err = multi_err_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a key-matrix model

module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  keypad_if kp ();

  keypad_scanner #(
    .SCAN_TICKS  (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  int checks = 0;
  int errors = 0;

  // Physical keypad: a pressed key connects its column line to its row line.
  logic [15:0] pressed;
  logic [3:0]  row_drv;

  always_comb begin
    row_drv = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (kp.col[3-c] && pressed[4*r+c]) row_drv[3-r] = 1'b1;
      end
    end
  end

  assign kp.row = row_drv;

  // Reference model: the accepted keypad state is whatever set of keys has
  // been held long enough; a strobe is owed when that state goes from empty
  // to exactly one key.
  logic [15:0] model_deb;
  logic [3:0]  sb[$];

  function automatic int pop16(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int idx16(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] one = 16'h0001;
    return one << (4*r + c);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [15:0] v);
    if (v != model_deb) begin
      if (model_deb == 16'h0000 && pop16(v) == 1) sb.push_back(4'(idx16(v)));
      model_deb = v;
    end
  endtask

  task automatic wait_and_check(input int sweeps);
    repeat (sweeps * 16) @(negedge clk);
    check("key_held", int'(kp.key_held), int'(model_deb != 16'h0000));
    check("multi_err", int'(kp.multi_err), int'(pop16(model_deb) > 1));
    check("strobes_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic hold(input logic [15:0] v, input int sweeps);
    model_step(v);
    pressed = v;
    wait_and_check(sweeps);
  endtask

  // Only used from an empty accepted state: the bounce window is too short
  // for the scanner to accept two different states inside it.
  task automatic bounce(input logic [15:0] v, input int half);
    model_step(v);
    for (int t = 0; t < 64; t++) begin
      pressed = ((t / half) % 2 == 0) ? v : 16'h0000;
      @(negedge clk);
    end
    pressed = v;
    wait_and_check(8);
  endtask

  // Monitor: every strobe must match the oldest owed key code.
  logic prev_valid = 1'b0;
  logic [3:0] exp_code;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (kp.key_valid) begin
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL strobe_width key_valid high two cycles at %0t", $time);
        end
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe got code=%0d want no strobe at %0t", kp.key_code, $time);
        end else begin
          exp_code = sb.pop_front();
          if (kp.key_code != exp_code) begin
            errors++;
            $display("FAIL key_code got=%0d want=%0d at %0t", kp.key_code, exp_code, $time);
          end
          if (!kp.key_held) begin
            errors++;
            $display("FAIL held_at_strobe got=0 want=1 at %0t", $time);
          end
        end
      end
      prev_valid = kp.key_valid;
    end
  end

  initial begin
    logic [15:0] v;
    int k1, k2, kind;

    rst       = 1'b1;
    pressed   = 16'h0000;
    model_deb = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_col", int'(kp.col), 8);
    check("reset_valid", int'(kp.key_valid), 0);
    check("reset_code", int'(kp.key_code), 0);
    check("reset_held", int'(kp.key_held), 0);
    check("reset_multi", int'(kp.multi_err), 0);

    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("col_walk", int'(kp.col), 8 >> (((i + 1) / 4) % 4));
    end
    @(negedge clk);

    hold(key(0, 1), 10);
    hold(16'h0000, 5);
    hold(key(3, 0), 8);
    hold(16'h0000, 8);
    hold(key(2, 0), 8);
    hold(16'h0000, 8);

    bounce(key(2, 0), 8);
    hold(16'h0000, 8);

    hold(key(0, 1) | key(2, 0), 8);
    hold(key(0, 1), 8);
    hold(16'h0000, 8);
    hold(key(0, 1), 8);

    // Reset while R0 C1 is accepted and still held down.
    rst = 1'b1;
    #1;
    check("midrst_col", int'(kp.col), 8);
    check("midrst_valid", int'(kp.key_valid), 0);
    check("midrst_code", int'(kp.key_code), 0);
    check("midrst_held", int'(kp.key_held), 0);
    check("midrst_multi", int'(kp.multi_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    model_deb = 16'h0000;
    hold(key(0, 1), 8);
    hold(16'h0000, 8);

    for (int p = 0; p < 20; p++) begin
      kind = int'($urandom_range(0, 3));
      k1   = int'($urandom_range(0, 15));
      k2   = (k1 + int'($urandom_range(1, 15))) % 16;
      case (kind)
        0: hold(16'h0000, 8);
        1: hold(key(k1 / 4, k1 % 4), 8);
        2: begin
          v = key(k1 / 4, k1 % 4) | key(k2 / 4, k2 % 4);
          hold(v, 8);
        end
        default: begin
          if (model_deb == 16'h0000) bounce(key(k1 / 4, k1 % 4), int'($urandom_range(1, 12)));
          else hold(16'h0000, 8);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
